cg_mem_write_buffer: RTL

//  Posted-write buffer sitting directly upstream of cg_memory_beh; drives its write/read request ports.

---
 rtl/cg_mem_wbuf_pkg.sv | 27 ++
 rtl/cg_wbuf_match.sv | 43 ++++
 rtl/cg_mem_write_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cg_mem_wbuf_pkg.sv
// -----------------------------------------------------------------------------
// cg_mem_wbuf_pkg
// Shared types for the posted-write buffer (cg_mem_write_buffer) and its
// youngest-hit search (cg_wbuf_match).
//   WBUF_ADDR_W / WBUF_DATA_W : entry field widths; the buffer's ADDR_WIDTH and
//                               DATA_WIDTH parameters default to these
//   wbuf_entry_t              : one buffered write {addr, data}
//   rd_state_e                : read-path state
// -----------------------------------------------------------------------------
package cg_mem_wbuf_pkg;

  localparam int WBUF_ADDR_W = 32;
  localparam int WBUF_DATA_W = 32;

  typedef struct packed {
    logic [WBUF_ADDR_W-1:0] addr;
    logic [WBUF_DATA_W-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } rd_state_e;

endpackage

// File: rtl/cg_wbuf_match.sv
// -----------------------------------------------------------------------------
// cg_wbuf_match
// Combinational search of the write buffer for the youngest valid entry whose
// address equals the query address.
// Ports:
//   i_addrs  : all entry addresses, slot k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   i_head   : slot index of the oldest entry
//   i_count  : number of valid entries, counted from i_head
//   i_query  : address to look for
//   o_hit    : at least one valid entry matches
//   o_idx    : slot of the youngest matching entry (0 when no hit)
// -----------------------------------------------------------------------------
module cg_wbuf_match #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [DEPTH*ADDR_WIDTH-1:0] i_addrs,
  input  logic [$clog2(DEPTH)-1:0]    i_head,
  input  logic [$clog2(DEPTH):0]      i_count,
  input  logic [ADDR_WIDTH-1:0]       i_query,
  output logic                        o_hit,
  output logic [$clog2(DEPTH)-1:0]    o_idx
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] slot;

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = i_head + PTR_W'(k);
      if ((k < int'(i_count)) && (i_addrs[slot*ADDR_WIDTH +: ADDR_WIDTH] == i_query)) begin
        o_hit = 1'b1;
        o_idx = slot;
      end
    end
  end

endmodule

// File: rtl/cg_mem_write_buffer.sv
// -----------------------------------------------------------------------------
// cg_mem_write_buffer
// Posted-write buffer in front of cg_memory_beh. CPU writes are queued in a
// DEPTH-entry FIFO and drained to memory one per cycle; CPU reads are answered
// from the buffer on an address hit or through a single memory read.
//
// Build option: CG_WBUF_FWD_EN
//   defined   : a read hit is forwarded from the youngest matching entry
//   undefined : a read hit is held off (o_rready=0) until no matching entry
//               remains, then served from memory
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_wvalid/o_wready/i_waddr/i_wdata      CPU write channel
//   i_rvalid/o_rready/i_raddr              CPU read request
//   o_rdata_valid/i_rdata_ready/o_rdata    CPU read response
//   o_mem_wen/o_mem_wdata_valid/i_mem_wready/o_mem_waddr/o_mem_wdata
//                                          head entry toward memory
//   o_mem_raddr_valid/i_mem_raddr_ready/o_mem_raddr   memory read request
//   i_mem_rdata_valid/i_mem_rdata/o_mem_rdata_ready   memory read data
//
// Read path states:
//   state  | meaning
//   R_IDLE | ready for a CPU read (unless held off by a buffered match)
//   R_REQ  | memory read address presented, waiting for i_mem_raddr_ready
//   R_WAIT | waiting for memory read data
//   R_RESP | response presented on o_rdata until the CPU takes it
// -----------------------------------------------------------------------------
module cg_mem_write_buffer
  import cg_mem_wbuf_pkg::*;
#(
  parameter int DATA_WIDTH = WBUF_DATA_W,
  parameter int ADDR_WIDTH = WBUF_ADDR_W,
  parameter int DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic                  o_rdata_valid,
  input  logic                  i_rdata_ready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_mem_wen,
  output logic                  o_mem_wdata_valid,
  input  logic                  i_mem_wready,
  output logic [ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_raddr_valid,
  input  logic                  i_mem_raddr_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  input  logic                  i_mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_mem_rdata_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_entry_t            entries_q [DEPTH];
  wbuf_entry_t            entries_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  rd_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;

  logic                   full, has_head, push, pop;
  logic                   rd_stall, rready, rd_accept;
  logic [DEPTH*ADDR_WIDTH-1:0] match_addrs;
  logic                   match_hit;
  logic [PTR_W-1:0]       match_idx;

  // Full depends only on the registered count, so o_wready never waits on a
  // same-cycle pop.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign has_head = (count_q != '0);
  assign push     = i_wvalid & ~full;
  assign pop      = has_head & i_mem_wready;

  always_comb begin
    match_addrs = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_addrs[k*ADDR_WIDTH +: ADDR_WIDTH] = entries_q[k].addr;
    end
  end

  // Searches the registered contents only: a write accepted in the same
  // cycle as the read is ordered after it.
  cg_wbuf_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_match (
    .i_addrs (match_addrs),
    .i_head  (rd_ptr_q),
    .i_count (count_q),
    .i_query (i_raddr),
    .o_hit   (match_hit),
    .o_idx   (match_idx)
  );

`ifdef CG_WBUF_FWD_EN
  assign rd_stall = 1'b0;
`else
  logic unused_match_idx;
  assign unused_match_idx = ^match_idx;
  assign rd_stall = match_hit;
`endif

  assign rready    = (state_q == R_IDLE) & ~rd_stall;
  assign rd_accept = i_rvalid & rready;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      entries_d[wr_ptr_q].addr = i_waddr;
      entries_d[wr_ptr_q].data = i_wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    raddr_d = raddr_q;
    case (state_q)
      R_IDLE: begin
        if (rd_accept) begin
`ifdef CG_WBUF_FWD_EN
          if (match_hit) begin
            // Snapshot now; a pop of that entry later does not matter.
            state_d = R_RESP;
            rdata_d = entries_q[match_idx].data;
          end else begin
            state_d = R_REQ;
            raddr_d = i_raddr;
          end
`else
          state_d = R_REQ;
          raddr_d = i_raddr;
`endif
        end
      end
      R_REQ: begin
        if (i_mem_raddr_ready) state_d = R_WAIT;
      end
      R_WAIT: begin
        if (i_mem_rdata_valid) begin
          state_d = R_RESP;
          rdata_d = i_mem_rdata;
        end
      end
      R_RESP: begin
        if (i_rdata_ready) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) entries_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= R_IDLE;
      rdata_q  <= '0;
      raddr_q  <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
    end
  end

  assign o_wready          = ~full;
  assign o_rready          = rready;
  assign o_rdata_valid     = (state_q == R_RESP);
  assign o_rdata           = rdata_q;
  assign o_mem_wen         = has_head;
  assign o_mem_wdata_valid = has_head;
  assign o_mem_waddr       = entries_q[rd_ptr_q].addr;
  assign o_mem_wdata       = entries_q[rd_ptr_q].data;
  assign o_mem_raddr_valid = (state_q == R_REQ);
  assign o_mem_raddr       = raddr_q;
  assign o_mem_rdata_ready = (state_q == R_WAIT);

endmodule
